// File: rtl/clock_pulse_monitor.sv
// clock_pulse_monitor: checks divided-clock pulse spacing, locks after LOCK_CNT good periods, flags errors.
// Optional: define PULSE_WIDTH_CHK_EN to also treat pulses wider than one CLK cycle as errors.
module clock_pulse_monitor #(
    parameter int DIV = 2,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W = 8,
    localparam int PW = $clog2(2*DIV+1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             PULSE_IN,
    input  logic             ERR_CLR,
    output logic             LOCKED,
    output logic             ERROR,
    output logic [ERR_W-1:0] ERR_COUNT,
    output logic [PW-1:0]    PERIOD_LAST
);
    localparam int GW = $clog2(LOCK_CNT+1);

    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED, S_FAULT} state_t;

    state_t state_q, state_d;
    logic p_q, seen_q, seen_d, rise, wide, meas, good, timeout, bad, err_evt, error_d;
    logic [PW-1:0] per_cnt_q, per_cnt_d, period_d;
    logic [GW-1:0] good_q, good_d;
    logic [ERR_W-1:0] cnt_base, cnt_d;

    assign rise = PULSE_IN & ~p_q;
`ifdef PULSE_WIDTH_CHK_EN
    assign wide = PULSE_IN & p_q;
`else
    assign wide = 1'b0;
`endif
    assign meas = rise & seen_q;
    assign good = meas && per_cnt_q == PW'(DIV);
    // Without a rise the counter can only reach 2*DIV, where it times out.
    assign timeout = seen_q && !rise && per_cnt_q == PW'(2*DIV);
    assign bad = (meas & ~good) | timeout | wide;

    always_comb begin
        state_d = state_q;
        per_cnt_d = per_cnt_q;
        seen_d = seen_q;
        good_d = good_q;
        period_d = PERIOD_LAST;
        err_evt = 1'b0;
        if (!ENABLE || state_q == S_IDLE || state_q == S_FAULT) begin
            state_d = ENABLE ? S_ACQUIRE : S_IDLE;
            per_cnt_d = '0;
            seen_d = 1'b0;
            good_d = '0;
        end else begin
            per_cnt_d = rise ? PW'(1) : timeout ? '0 : seen_q ? per_cnt_q + 1'b1 : per_cnt_q;
            seen_d = rise | (seen_q & ~timeout);
            period_d = meas ? per_cnt_q : PERIOD_LAST;
            if (state_q == S_ACQUIRE) begin
                good_d = bad ? '0 : good ? good_q + 1'b1 : good_q;
                state_d = (good && good_q == GW'(LOCK_CNT-1)) ? S_LOCKED : S_ACQUIRE;
            end else if (bad) begin
                state_d = S_FAULT;
                err_evt = 1'b1;
            end
        end
        // A new error in the same cycle as ERR_CLR lands on top of the cleared value.
        error_d = err_evt | (ERROR & ~ERR_CLR);
        cnt_base = ERR_CLR ? '0 : ERR_COUNT;
        cnt_d = (err_evt && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            p_q <= 1'b0;
            per_cnt_q <= '0;
            seen_q <= 1'b0;
            good_q <= '0;
            LOCKED <= 1'b0;
            ERROR <= 1'b0;
            ERR_COUNT <= '0;
            PERIOD_LAST <= '0;
        end else begin
            state_q <= state_d;
            p_q <= PULSE_IN;
            per_cnt_q <= per_cnt_d;
            seen_q <= seen_d;
            good_q <= good_d;
            LOCKED <= state_d == S_LOCKED;
            ERROR <= error_d;
            ERR_COUNT <= cnt_d;
            PERIOD_LAST <= period_d;
        end
    end
endmodule

// File: tb/tb_clock_pulse_monitor.sv
// tb_clock_pulse_monitor: directed and randomized checks against a timestamp-based model of the monitor.
module tb_clock_pulse_monitor;
    localparam int DIV = 2;
    localparam int LOCK_CNT = 4;
    localparam int ERR_W = 2;
    localparam int PW = $clog2(2*DIV+1);
    localparam int MAXC = (1 << ERR_W) - 1;
`ifdef PULSE_WIDTH_CHK_EN
    localparam bit WCHK = 1'b1;
`else
    localparam bit WCHK = 1'b0;
`endif

    logic CLK = 1'b0, RESET = 1'b0, ENABLE = 1'b0, PULSE_IN = 1'b0, ERR_CLR = 1'b0;
    logic LOCKED, ERROR;
    logic [ERR_W-1:0] ERR_COUNT;
    logic [PW-1:0] PERIOD_LAST;
    int tests = 0, fails = 0;
    bit chk_on = 1'b0;

    clock_pulse_monitor #(.DIV(DIV), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PULSE_IN(PULSE_IN), .ERR_CLR(ERR_CLR),
        .LOCKED(LOCKED), .ERROR(ERROR), .ERR_COUNT(ERR_COUNT), .PERIOD_LAST(PERIOD_LAST)
    );

    always #5 CLK = ~CLK;

    // Model: mode 0 idle, 1 acquire, 2 locked, 3 fault; pulses tracked by cycle timestamp.
    int mode = 0, last = -1, goods = 0, cyc_n = 0, m_cnt = 0, m_per = 0;
    bit m_locked = 1'b0, m_err = 1'b0, m_pq = 1'b0;

    always @(posedge CLK or posedge RESET) begin
        bit rise, bad, evt;
        int nmode;
        if (RESET) begin
            mode = 0; last = -1; goods = 0; m_cnt = 0; m_per = 0;
            m_locked = 1'b0; m_err = 1'b0; m_pq = 1'b0;
        end else begin
            cyc_n++;
            rise = PULSE_IN && !m_pq;
            bad = WCHK && PULSE_IN && m_pq;
            m_pq = PULSE_IN;
            evt = 1'b0;
            nmode = mode;
            if (!ENABLE || mode == 0 || mode == 3) begin
                nmode = ENABLE ? 1 : 0;
                last = -1;
                goods = 0;
            end else begin
                if (rise) begin
                    if (last >= 0) begin
                        m_per = cyc_n - last;
                        if (m_per != DIV) bad = 1'b1;
                        else if (mode == 1) goods++;
                    end
                    last = cyc_n;
                end else if (last >= 0 && cyc_n - last == 2*DIV) begin
                    bad = 1'b1;
                    last = -1;
                end
                if (mode == 1) begin
                    if (bad) goods = 0;
                    else if (goods >= LOCK_CNT) nmode = 2;
                end else if (bad) begin
                    nmode = 3;
                    evt = 1'b1;
                end
            end
            if (ERR_CLR) begin m_err = 1'b0; m_cnt = 0; end
            if (evt) begin m_err = 1'b1; if (m_cnt < MAXC) m_cnt++; end
            mode = nmode;
            m_locked = mode == 2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) if (chk_on) begin
        chk("locked", 32'(LOCKED), 32'(m_locked));
        chk("error", 32'(ERROR), 32'(m_err));
        chk("err_count", 32'(ERR_COUNT), m_cnt);
        chk("period_last", 32'(PERIOD_LAST), m_per);
    end

    task automatic cyc(input bit e, input bit p, input bit c);
        ENABLE = e; PULSE_IN = p; ERR_CLR = c;
        @(negedge CLK);
    endtask

    task automatic relock();
        cyc(1, 0, 0);
        repeat (5) begin cyc(1, 1, 0); cyc(1, 0, 0); end
    endtask

    task automatic err_round(input bit c);
        relock();
        cyc(1, 0, 0);
        cyc(1, 1, c);
    endtask

    initial begin
        int r, ph;
        bit e, p, c;
        #1 RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_locked", 32'(LOCKED), 0);
        chk("rst_error", 32'(ERROR), 0);
        chk("rst_count", 32'(ERR_COUNT), 0);
        chk("rst_period", 32'(PERIOD_LAST), 0);
        RESET = 1'b0;
        chk_on = 1'b1;
        // Lock from reset: 5th rise completes the 4th good period.
        cyc(1, 0, 0);
        repeat (4) begin cyc(1, 1, 0); cyc(1, 0, 0); end
        chk("pre_lock", 32'(LOCKED), 0);
        cyc(1, 1, 0);
        chk("lock", 32'(LOCKED), 1);
        chk("lock_error", 32'(ERROR), 0);
        chk("lock_period", 32'(PERIOD_LAST), 2);
        // Missing pulse.
        repeat (3) cyc(1, 0, 0);
        chk("pre_timeout", 32'(LOCKED), 1);
        cyc(1, 0, 0);
        chk("timeout_locked", 32'(LOCKED), 0);
        chk("timeout_error", 32'(ERROR), 1);
        chk("timeout_count", 32'(ERR_COUNT), 1);
        cyc(1, 0, 0);
        repeat (4) begin cyc(1, 1, 0); cyc(1, 0, 0); end
        cyc(1, 1, 0);
        chk("relock", 32'(LOCKED), 1);
        // Stretched period.
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0);
        chk("stretch_period", 32'(PERIOD_LAST), 3);
        chk("stretch_count", 32'(ERR_COUNT), 2);
        chk("stretch_locked", 32'(LOCKED), 0);
        // Saturation and clear-vs-error priority.
        err_round(0);
        err_round(0);
        chk("sat_count", 32'(ERR_COUNT), 3);
        err_round(1);
        chk("clr_err_count", 32'(ERR_COUNT), 1);
        chk("clr_err_error", 32'(ERROR), 1);
        cyc(1, 0, 1);
        chk("clr_count", 32'(ERR_COUNT), 0);
        chk("clr_error", 32'(ERROR), 0);
        // Async reset between edges while locked.
        err_round(0);
        relock();
        chk("pre_rst_locked", 32'(LOCKED), 1);
        chk("pre_rst_count", 32'(ERR_COUNT), 1);
        #2 RESET = 1'b1;
        #1;
        chk("arst_locked", 32'(LOCKED), 0);
        chk("arst_error", 32'(ERROR), 0);
        chk("arst_count", 32'(ERR_COUNT), 0);
        chk("arst_period", 32'(PERIOD_LAST), 0);
        @(negedge CLK);
        RESET = 1'b0;
        // ENABLE low while locked keeps the error flag.
        err_round(0);
        relock();
        cyc(0, 0, 0);
        chk("dis_locked", 32'(LOCKED), 0);
        chk("dis_error", 32'(ERROR), 1);
        // Two-cycle-wide pulse while locked.
        cyc(1, 0, 1);
        relock();
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        chk("wide_error", 32'(ERROR), 32'(WCHK));
        // Mostly-periodic random pulses with jitter, dropouts, enables and clears.
        ph = 0;
        repeat (3000) begin
            r = $urandom_range(0, 99);
            e = $urandom_range(0, 63) != 0;
            c = $urandom_range(0, 99) == 0;
            ph = (ph + 1) % DIV;
            if (r < 4) ph = $urandom_range(0, DIV - 1);
            p = (r < 90) ? (ph == 0) : 1'($urandom_range(0, 1));
            cyc(e, p, c);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
